// File: rtl/rf_pkg.sv
// Shared constants and address type for the 32-entry register file.
package rf_pkg;

  localparam int RF_DEPTH  = 32;
  localparam int RF_ADDR_W = 5;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;

  // True when an enabled write targets a real (nonzero) register at the given address.
  function automatic logic rf_addr_hit(input logic we, input rf_addr_t wr_addr, input rf_addr_t addr);
    return we && (wr_addr != '0) && (wr_addr == addr);
  endfunction

endpackage

// File: rtl/register_file_2r1w_if.sv
// Decode/writeback-side bus of the register file: write port, two read ports and the register-1 tap.
interface register_file_2r1w_if #(parameter int N = 32);
  import rf_pkg::*;

  logic         Reg_Write_i;
  rf_addr_t     Write_Register_i;
  rf_addr_t     Read_Register_1_i;
  rf_addr_t     Read_Register_2_i;
  logic [N-1:0] Write_Data_i;
  logic [N-1:0] Read_Data_1_o;
  logic [N-1:0] Read_Data_2_o;
  logic [N-1:0] Q1;

  modport master (
    output Reg_Write_i, Write_Register_i, Read_Register_1_i, Read_Register_2_i, Write_Data_i,
    input  Read_Data_1_o, Read_Data_2_o, Q1
  );

  modport slave (
    input  Reg_Write_i, Write_Register_i, Read_Register_1_i, Read_Register_2_i, Write_Data_i,
    output Read_Data_1_o, Read_Data_2_o, Q1
  );
endinterface

// File: rtl/rf_reg_cell.sv
// One N-bit architectural register: load enable plus asynchronous active-low clear.
module rf_reg_cell #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] q_o
);

  logic [N-1:0] q_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/register_file_2r1w.sv
// 32 x N register file, two combinational read ports, one synchronous write port, register-1 tap.
// Define RF_WRITE_BYPASS_EN to forward same-cycle write data onto matching read ports and Q1.
module register_file_2r1w
  import rf_pkg::*;
#(
  parameter int N = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  register_file_2r1w_if.slave  rf
);

  logic               we_eff;
  logic [RF_DEPTH-1:1] wr_en;
  logic [N-1:0]       reg_q [RF_DEPTH];
  logic [N-1:0]       rd1;
  logic [N-1:0]       rd2;
  logic [N-1:0]       tap;

  // Reset also masks the write so forwarding cannot leak data while the file is held clear.
  assign we_eff = rf.Reg_Write_i & reset;

  // NOTE: always_comb assigns a default before any conditional update, so no latch is inferred.
  always_comb begin
    wr_en = '0;
    for (int i = 1; i < RF_DEPTH; i++) begin
      wr_en[i] = rf_addr_hit(we_eff, rf.Write_Register_i, rf_addr_t'(i));
    end
  end

  assign reg_q[0] = '0;

  for (genvar g = 1; g < RF_DEPTH; g++) begin : g_reg
    rf_reg_cell #(.N(N)) u_cell (
      .clk   (clk),
      .reset (reset),
      .en_i  (wr_en[g]),
      .d_i   (rf.Write_Data_i),
      .q_o   (reg_q[g])
    );
  end

  always_comb begin
    rd1 = reg_q[rf.Read_Register_1_i];
    rd2 = reg_q[rf.Read_Register_2_i];
    tap = reg_q[1];
`ifdef RF_WRITE_BYPASS_EN
    if (rf_addr_hit(we_eff, rf.Write_Register_i, rf.Read_Register_1_i)) rd1 = rf.Write_Data_i;
    if (rf_addr_hit(we_eff, rf.Write_Register_i, rf.Read_Register_2_i)) rd2 = rf.Write_Data_i;
    if (wr_en[1]) tap = rf.Write_Data_i;
`endif
  end

  assign rf.Read_Data_1_o = rd1;
  assign rf.Read_Data_2_o = rd2;
  assign rf.Q1            = tap;

endmodule

// File: tb/tb_register_file_2r1w.sv
// Self-checking bench: array model of the 32 registers checked every negedge, plus directed literal checks.
module tb_register_file_2r1w;
  import rf_pkg::*;

  localparam int N = 32;

`ifdef RF_WRITE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  register_file_2r1w_if #(.N(N)) rf_bus ();

  register_file_2r1w #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .rf    (rf_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: plain array of register contents.
  logic [N-1:0] model [RF_DEPTH];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RF_DEPTH; i++) model[i] = '0;
    end else if (rf_bus.Reg_Write_i && rf_bus.Write_Register_i != 0) begin
      model[rf_bus.Write_Register_i] = rf_bus.Write_Data_i;
    end
  end

  function automatic logic [N-1:0] expect_read(input int addr);
    if (BYPASS && reset && rf_bus.Reg_Write_i && rf_bus.Write_Register_i != 0 &&
        int'(rf_bus.Write_Register_i) == addr)
      return rf_bus.Write_Data_i;
    return model[addr];
  endfunction

  task automatic check(input string name, input logic [N-1:0] actual, input logic [N-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Continuous compare against the model, away from the active edge.
  always @(negedge clk) begin
    check("model_rd1", rf_bus.Read_Data_1_o, expect_read(int'(rf_bus.Read_Register_1_i)));
    check("model_rd2", rf_bus.Read_Data_2_o, expect_read(int'(rf_bus.Read_Register_2_i)));
    check("model_q1",  rf_bus.Q1,            expect_read(1));
  end

  task automatic drive(input logic we, input int wa, input logic [N-1:0] wd, input int ra1, input int ra2);
    rf_bus.Reg_Write_i       = we;
    rf_bus.Write_Register_i  = rf_addr_t'(wa);
    rf_bus.Write_Data_i      = wd;
    rf_bus.Read_Register_1_i = rf_addr_t'(ra1);
    rf_bus.Read_Register_2_i = rf_addr_t'(ra2);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 0, '0, 0, 2);
    #3;
    check("rst_rd_addr0", rf_bus.Read_Data_1_o, 32'd0);
    check("rst_rd_addr2", rf_bus.Read_Data_2_o, 32'd0);
    check("rst_q1", rf_bus.Q1, 32'd0);
    rf_bus.Read_Register_1_i = 5'd31;
    #1;
    check("rst_rd_addr31", rf_bus.Read_Data_1_o, 32'd0);

    tick();
    reset = 1'b1;

    drive(1'b1, 2, 32'd7, 0, 0);   tick();
    drive(1'b1, 4, 32'd20, 0, 0);  tick();
    drive(1'b1, 25, 32'd6, 0, 0);  tick();
    drive(1'b1, 31, 32'd78, 0, 0); tick();

    drive(1'b0, 0, '0, 2, 4);
    #1;
    check("wr_rd1_r2", rf_bus.Read_Data_1_o, 32'd7);
    check("wr_rd2_r4", rf_bus.Read_Data_2_o, 32'd20);
    drive(1'b0, 0, '0, 25, 31);
    #1;
    check("wr_rd1_r25", rf_bus.Read_Data_1_o, 32'd6);
    check("wr_rd2_r31", rf_bus.Read_Data_2_o, 32'd78);
    drive(1'b0, 0, '0, 31, 2);
    #1;
    check("wr_rd1_r31", rf_bus.Read_Data_1_o, 32'd78);
    check("wr_rd2_r2", rf_bus.Read_Data_2_o, 32'd7);

    tick();
    drive(1'b0, 4, 32'hDEAD, 4, 4); tick();
    check("wdis_rd1_r4", rf_bus.Read_Data_1_o, 32'd20);
    check("wdis_rd2_r4", rf_bus.Read_Data_2_o, 32'd20);

    drive(1'b1, 0, 32'd3, 0, 0); tick();
    drive(1'b0, 0, 32'd3, 0, 0);
    #1;
    check("r0_rd1", rf_bus.Read_Data_1_o, 32'd0);
    check("r0_rd2", rf_bus.Read_Data_2_o, 32'd0);

    drive(1'b1, 1, 32'd5, 2, 31); tick();
    rf_bus.Reg_Write_i = 1'b0;
    #1;
    check("q1_5", rf_bus.Q1, 32'd5);
    check("q1_rd1_r2", rf_bus.Read_Data_1_o, 32'd7);
    check("q1_rd2_r31", rf_bus.Read_Data_2_o, 32'd78);
    tick();
    drive(1'b1, 1, 32'd9, 2, 31); tick();
    rf_bus.Reg_Write_i = 1'b0;
    #1;
    check("q1_9", rf_bus.Q1, 32'd9);

    tick();
    drive(1'b1, 4, 32'h55, 4, 25);
    #1;
    check("byp_pre_rd1", rf_bus.Read_Data_1_o, BYPASS ? 32'h55 : 32'd20);
    check("byp_pre_rd2", rf_bus.Read_Data_2_o, 32'd6);
    tick();
    rf_bus.Reg_Write_i = 1'b0;
    #1;
    check("byp_post_rd1", rf_bus.Read_Data_1_o, 32'h55);

    tick();
    drive(1'b1, 1, 32'h77, 4, 1);
    #1;
    check("byp_pre_q1", rf_bus.Q1, BYPASS ? 32'h77 : 32'd9);
    check("byp_pre_rd2_r1", rf_bus.Read_Data_2_o, BYPASS ? 32'h77 : 32'd9);
    tick();
    drive(1'b1, 25, 32'h1234, 4, 25);
    #1;
    reset = 1'b0;
    #1;
    check("mid_rst_rd1", rf_bus.Read_Data_1_o, 32'd0);
    check("mid_rst_rd2", rf_bus.Read_Data_2_o, 32'd0);
    check("mid_rst_q1", rf_bus.Q1, 32'd0);
    tick();
    check("rst_hold_rd2", rf_bus.Read_Data_2_o, 32'd0);
    reset = 1'b1;
    drive(1'b0, 0, '0, 4, 25);
    tick();
    check("post_rst_rd1", rf_bus.Read_Data_1_o, 32'd0);
    check("post_rst_rd2", rf_bus.Read_Data_2_o, 32'd0);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
